uart_tx_fifo: RTL and testbench

//   UART transmitter: serialises bytes onto o_Tx as 8N1 frames (LSB first, one start bit, one stop bit).

---
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed from a small byte FIFO; queued frames go out back-to-back.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop (PARITY_ODD selects odd parity).
module uart_tx_fifo #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fValid,
  input  logic [7:0] i_Data,
  output logic       o_fReady,
  output logic       o_Tx,
  output logic       o_fBusy,
  output logic       o_fDone
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_CNT = CW'(CLKS_PER_BIT - 2);

  if (CLKS_PER_BIT < 2) begin : gBadClksPerBit
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : gBadDepth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParity
    $error("PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic          empty, full, push, pop;
  logic [7:0]    head;

  state_e        state_q;
  logic [CW-1:0] clkCnt_q;
  logic [2:0]    bitCnt_q;
  logic [2:0]    nextBit;
  logic [7:0]    data_q;
  logic          tx_q, busy_q, done_q;
  logic          lastClk;

  // Pointers carry one extra wrap bit so full and empty are told apart.
  assign empty   = (wrPtr_q == rdPtr_q);
  assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign push    = i_fValid && !full;
  assign head    = mem_q[rdPtr_q[AW-1:0]];
  assign lastClk = (clkCnt_q == LAST_CNT);
  assign nextBit = bitCnt_q + 3'd1;
  assign pop     = !empty && ((state_q == IDLE) || ((state_q == STOP) && lastClk));

  always_comb begin
    wrPtr_d = wrPtr_q + PW'(push);
    rdPtr_d = rdPtr_q + PW'(pop);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= i_Data;
  end

`ifdef UART_TX_PARITY_EN
  logic parityBit;
  assign parityBit = (PARITY_ODD != 0) ? ~^data_q : ^data_q;
`endif

  // o_Tx is loaded with the level of the state being entered, so it stays glitch-free.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q  <= IDLE;
      clkCnt_q <= '0;
      bitCnt_q <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= (state_q == STOP) && (clkCnt_q == DONE_CNT);
      clkCnt_q <= ((state_q == IDLE) || lastClk) ? '0 : clkCnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          if (pop) begin
            data_q  <= head;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (lastClk) begin
            state_q  <= DATA;
            bitCnt_q <= '0;
            tx_q     <= data_q[0];
          end
        end
        DATA: begin
          if (lastClk) begin
            if (bitCnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parityBit;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bitCnt_q <= nextBit;
              tx_q     <= data_q[nextBit];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (lastClk) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (lastClk) begin
            if (pop) begin
              data_q  <= head;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_fReady = !full;
  assign o_Tx     = tx_q;
  assign o_fBusy  = busy_q;
  assign o_fDone  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random and directed stimulus checked cycle by cycle against a queue-based frame model,
// plus a behavioural loopback receiver that decodes o_Tx and matches bytes in order.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam bit PAR_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CPB;

  logic       clk;
  logic       rstN;
  logic       validIn;
  logic [7:0] dataIn;
  logic       ready, tx, busy, done;

  int total = 0;
  int bad   = 0;

  // Reference model: pending byte queue plus the edge at which the current frame started.
  int         n = 0;
  logic [7:0] q[$];
  logic [7:0] sb[$];
  bit         active = 0;
  int         fStart = 0;
  logic [7:0] cur = 8'h00;
  bit         lastAccept = 0;
  int         doneSeen = 0;
  bit         sawNotReady = 0;
  bit         txLowSeen = 0;

  bit         rxOn = 0;
  int         rxPh = 0;
  logic [7:0] rxByte = 8'h00;
  int         rxCount = 0;

  uart_tx_fifo #(
    .CLK_HZ(1_000_000),
    .BAUD(250_000),
    .FIFO_DEPTH(DEPTH),
    .PARITY_ODD(0)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rstN),
    .i_fValid(validIn),
    .i_Data(dataIn),
    .o_fReady(ready),
    .o_Tx(tx),
    .o_fBusy(busy),
    .o_fDone(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  function automatic logic expBit(input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return (^cur) ^ PAR_ODD;
`endif
    return 1'b1;
  endfunction

  task automatic modelEdge();
    n++;
    lastAccept = 0;
    if (rstN !== 1'b1) begin
      q.delete();
      sb.delete();
      active = 0;
      rxOn   = 0;
    end else begin
      lastAccept = (validIn === 1'b1) && (q.size() < DEPTH);
      if (active && (n - fStart) == FRAME_CLKS) active = 0;
      if (!active && q.size() > 0) begin
        cur    = q.pop_front();
        sb.push_back(cur);
        active = 1;
        fStart = n;
      end
      if (lastAccept) q.push_back(dataIn);
    end
  endtask

  task automatic stepClock();
    int idx;
    int b;
    @(posedge clk);
    modelEdge();
    #1;
    idx = n - fStart;
    checkOutput("tx", tx, active ? expBit(idx / CPB) : 1'b1);
    checkOutput("busy", busy, active);
    checkOutput("done", done, active && (idx == FRAME_CLKS - 1));
    checkOutput("ready", ready, q.size() < DEPTH);
    if (done === 1'b1) doneSeen++;
    if (ready === 1'b0) sawNotReady = 1;
    if (tx !== 1'b1) txLowSeen = 1;
    if (rstN === 1'b1) begin
      if (rxOn) begin
        rxPh++;
        if (rxPh % CPB == CPB / 2) begin
          b = rxPh / CPB;
          if (b >= 1 && b <= 8) rxByte[b-1] = tx;
          else if (b == FRAME_BITS - 1) checkOutput("rx_stop", tx, 1'b1);
        end
        if (rxPh == FRAME_CLKS - 1) begin
          rxOn = 0;
          rxCount++;
          checkOutput("rx_has_expected", sb.size() > 0, 1'b1);
          if (sb.size() > 0) checkOutput("rx_byte", rxByte, sb.pop_front());
        end
      end else if (tx === 1'b0) begin
        rxOn = 1;
        rxPh = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    validIn = v;
    dataIn  = d;
    rstN    = r;
    stepClock();
  endtask

  initial begin
    int d0;
    int r0;
    int guard;
    int byteNext;
    logic v;

    rstN = 1'b0; validIn = 1'b0; dataIn = 8'h00;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ready", ready, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    $display("[TB] single byte 0x55");
    d0 = doneSeen; r0 = rxCount;
    applyStimulus(1'b1, 8'h55, 1'b1);
    repeat (FRAME_CLKS + 5) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("single_done_count", doneSeen - d0, 1);
    checkOutput("single_rx_count", rxCount - r0, 1);

    $display("[TB] burst 0x01..0x06");
    d0 = doneSeen; r0 = rxCount; sawNotReady = 0; byteNext = 1; guard = 0;
    while (byteNext <= 6 && guard < 300) begin
      applyStimulus(1'b1, 8'(byteNext), 1'b1);
      if (lastAccept) byteNext++;
      guard++;
    end
    checkOutput("burst_accept_timeout", guard < 300, 1'b1);
    repeat (6 * FRAME_CLKS + 10) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("burst_done_count", doneSeen - d0, 6);
    checkOutput("burst_ready_dropped", sawNotReady, 1'b1);
    checkOutput("burst_rx_count", rxCount - r0, 6);

    $display("[TB] reset during data bit 3");
    applyStimulus(1'b1, 8'hA5, 1'b1);
    applyStimulus(1'b1, 8'h3C, 1'b1);
    applyStimulus(1'b1, 8'hF0, 1'b1);
    guard = 0;
    while (!(active && (n - fStart) == 4 * CPB + 1) && guard < 100) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      guard++;
    end
    checkOutput("midframe_wait_timeout", guard < 100, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midreset_tx", tx, 1'b1);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_ready", ready, 1'b1);
    txLowSeen = 0;
    repeat (100) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_reset_tx_idle", txLowSeen, 1'b0);

    $display("[TB] pointer wrap 0x00..0x09 with random gaps");
    r0 = rxCount; byteNext = 0; guard = 0;
    while (byteNext < 10 && guard < 3000) begin
      v = ($urandom_range(0, 2) != 0);
      applyStimulus(v, 8'(byteNext), 1'b1);
      if (lastAccept) byteNext++;
      guard++;
    end
    checkOutput("wrap_accept_timeout", guard < 3000, 1'b1);
    repeat (10 * FRAME_CLKS + 20) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("wrap_rx_count", rxCount - r0, 10);
    checkOutput("wrap_all_received", sb.size(), 0);

    $display("[TB] random bytes with random gaps");
    r0 = rxCount; byteNext = 0; guard = 0;
    while (byteNext < 20 && guard < 5000) begin
      v = ($urandom_range(0, 3) == 0);
      applyStimulus(v, 8'($urandom), 1'b1);
      if (lastAccept) byteNext++;
      guard++;
    end
    checkOutput("random_accept_timeout", guard < 5000, 1'b1);
    repeat (20 * FRAME_CLKS + 20) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("random_rx_count", rxCount - r0, 20);
    checkOutput("random_all_received", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
